multi_sig_proc: RTL and testbench

// - Parametrised N-channel signal conditioner; successor to the fixed 3-input/3-output x,y,z dut.
// - Each channel has its own mode: pass, invert, rising-edge pulse or retriggerable pulse stretch.
// - Configuration is shadowed and loaded atomically by strobe, so mode changes never glitch outputs.
// - Sits between raw control/status inputs and downstream logic that needs registered outputs.

---
 rtl/multi_sig_proc.sv | 105 ++++++++++
 tb/tb_multi_sig_proc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_sig_proc.sv
// N-channel signal conditioner: per-channel pass/invert/rise-pulse/stretch modes
// with shadowed configuration loaded atomically by cfg_load.
module multi_sig_proc #(
    parameter int N_CH  = 3,
    parameter int LEN_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*N_CH-1:0]   cfg_mode,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                cfg_load,
    input  logic [N_CH-1:0]     sig,
    output logic [N_CH-1:0]     out,
    output logic                busy
);

    typedef enum logic [1:0] {
        MODE_PASS    = 2'b00,
        MODE_INVERT  = 2'b01,
        MODE_RISE    = 2'b10,
        MODE_STRETCH = 2'b11
    } mode_e;

    logic [N_CH-1:0]   sig_q;
    logic [N_CH-1:0]   sig_qq;
    logic [N_CH-1:0]   out_q;
    logic [N_CH-1:0]   out_d;
    logic              busy_q;
    logic [N_CH-1:0]   cnt_nz_d;
    logic [2*N_CH-1:0] mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_eff;

    // A zero length would make the stretch vanish; treat it as one cycle.
    assign len_eff = (len_q == '0) ? LEN_W'(1) : len_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [LEN_W-1:0] cnt_q;
            logic [LEN_W-1:0] cnt_d;
            logic             out_ch_d;
            logic             rise;

            assign rise = sig_q[gi] & ~sig_qq[gi];

            always_comb begin
                cnt_d    = '0;
                out_ch_d = 1'b0;
                case (mode_e'(mode_q[2*gi +: 2]))
                    MODE_PASS:   out_ch_d = sig_q[gi];
                    MODE_INVERT: out_ch_d = ~sig_q[gi];
                    MODE_RISE:   out_ch_d = rise;
                    MODE_STRETCH: begin
                        if (rise) begin
                            cnt_d = len_eff;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end
                        out_ch_d = (cnt_d != '0);
                    end
                    default: out_ch_d = 1'b0;
                endcase
            end

            // Loading a new configuration restarts every channel from idle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (cfg_load) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign out_d[gi]    = out_ch_d;
            assign cnt_nz_d[gi] = (cnt_d != '0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= '0;
            sig_qq <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            mode_q <= '0;
            len_q  <= LEN_W'(1);
        end else begin
            sig_q  <= sig;
            sig_qq <= sig_q;
            out_q  <= out_d;
            busy_q <= cfg_load ? 1'b0 : (|cnt_nz_d);
            if (cfg_load) begin
                mode_q <= cfg_mode;
                len_q  <= cfg_len;
            end
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_multi_sig_proc.sv
// Directed bench for multi_sig_proc: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_multi_sig_proc;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] cfg_mode = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_load = 1'b0;
    logic [2:0] sig = 3'b111;
    logic [2:0] out;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    multi_sig_proc #(.N_CH(3), .LEN_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_mode (cfg_mode),
        .cfg_len  (cfg_len),
        .cfg_load (cfg_load),
        .sig      (sig),
        .out      (out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: sample history, remaining stretch cycles as integers.
    logic [2:0] m_s1, m_s2, m_out;
    logic       m_busy;
    int         m_mode [N];
    int         m_len;
    int         m_rem  [N];
    int         m_L;
    logic       m_rise;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_busy = 1'b0; m_len = 1;
            for (int c = 0; c < N; c++) begin
                m_mode[c] = 0;
                m_rem[c]  = 0;
            end
        end else begin
            m_L = (m_len == 0) ? 1 : m_len;
            m_busy = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_rise = m_s1[c] && !m_s2[c];
                if (m_mode[c] == 3) begin
                    if (m_rise) m_rem[c] = m_L;
                    else if (m_rem[c] > 0) m_rem[c] = m_rem[c] - 1;
                    m_out[c] = (m_rem[c] != 0);
                end else begin
                    m_rem[c] = 0;
                    if (m_mode[c] == 0) m_out[c] = m_s1[c];
                    else if (m_mode[c] == 1) m_out[c] = !m_s1[c];
                    else m_out[c] = m_rise;
                end
                if (m_rem[c] != 0) m_busy = 1'b1;
            end
            if (cfg_load) begin
                m_busy = 1'b0;
                m_len  = int'(cfg_len);
                for (int c = 0; c < N; c++) begin
                    m_rem[c]  = 0;
                    m_mode[c] = int'(cfg_mode[2*c +: 2]);
                end
            end
            m_s2 = m_s1;
            m_s1 = sig;
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (out !== m_out || busy !== m_busy) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t got out=%b busy=%b, want out=%b busy=%b",
                     $time, out, busy, m_out, m_busy);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] mode, input logic [3:0] len);
        cfg_mode = mode;
        cfg_len  = len;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        step();
        step();
    endtask

    // Drive sig[0] from pat (bit i before step i) and measure out[0]/busy.
    task automatic window(input int n, input logic [15:0] pat,
                          output int hi, output int busy_hi, output int rises);
        logic prev;
        prev = 1'b0; hi = 0; busy_hi = 0; rises = 0;
        for (int i = 0; i < n; i++) begin
            sig[0] = pat[i];
            step();
            if (out[0]) hi++;
            if (busy) busy_hi++;
            if (out[0] && !prev) rises++;
            prev = out[0];
        end
    endtask

    int hi, bh, rs;

    initial begin
        // Reset with all inputs high.
        step(); step();
        chk("reset_out", int'(out), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        step();
        chk("post_rst_edge1_out", int'(out), 0);
        step();
        chk("post_rst_edge2_out", int'(out), 7);

        // ch2 INVERT, ch1 PASS, ch0 RISE.
        sig = 3'b000;
        load(6'b01_00_10, 4'd0);
        chk("mixed_idle_out", int'(out), 3'b100);
        sig = 3'b111;
        step();
        chk("mixed_lat_out", int'(out), 3'b100);
        step();
        chk("mixed_rise_out", int'(out), 3'b011);
        step();
        chk("mixed_hold_out", int'(out), 3'b010);

        // ch0 STRETCH len 3, single pulse.
        sig = 3'b000;
        load(6'b00_00_11, 4'd3);
        window(8, 16'b0000_0001, hi, bh, rs);
        chk("stretch3_width", hi, 3);
        chk("stretch3_busy", bh, 3);

        // Retrigger two cycles after the first rise.
        window(10, 16'b0000_0101, hi, bh, rs);
        chk("retrig_width", hi, 5);
        chk("retrig_contig", rs, 1);

        // Length 0 behaves as 1.
        load(6'b00_00_11, 4'd0);
        window(5, 16'b0000_0001, hi, bh, rs);
        chk("len0_width", hi, 1);

        // Load during an active stretch with sig held high.
        load(6'b00_00_11, 4'd15);
        sig[0] = 1'b1;
        step(); step(); step(); step();
        chk("long_stretch_active", int'(out[0]), 1);
        cfg_load = 1'b1;
        step();
        chk("load_edge_old_mode", int'(out[0]), 1);
        cfg_load = 1'b0;
        step();
        chk("after_load_out", int'(out[0]), 0);
        chk("after_load_busy", int'(busy), 0);
        window(5, 16'hFFFF, hi, bh, rs);
        chk("no_spurious_pulse", hi, 0);

        // Asynchronous reset mid-stretch.
        sig = 3'b000;
        load(6'b00_00_11, 4'd3);
        sig[0] = 1'b1;
        step();
        sig[0] = 1'b0;
        step(); step();
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_busy", int'(busy), 0);
        step();
        sig = 3'b111;
        rst = 1'b0;
        step();
        chk("rst_release_edge1", int'(out), 0);
        step();
        chk("rst_release_pass", int'(out), 7);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
